// File: rtl/intellight_axil_regbank_if.sv
// AXI4-Lite bus bundle for the intellight register bank.
// The master modport belongs to the PS side (or the VIP/bench), and the slave modport to the register bank.
interface intellight_axil_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Write address channel
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/intellight_axil_regbank.sv
// Parametrised AXI4-Lite register bank.
// The low indices hold software-writable control registers with byte strobes.
// The top C_NUM_RO indices hold read-only status words supplied by the traffic light core.
// AW and W are captured into independent holding registers, so they can arrive in any order.
// Illegal accesses (RO writes and out-of-range addresses) return SLVERR.
module intellight_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS         = 8,
  parameter int C_NUM_RO           = 2,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RST_VAL = '0
) (
  input  logic ACLK,
  input  logic ARESETN,
  intellight_axil_regbank_if.slave s_axi,
  output logic [(C_NUM_REGS-C_NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-C_NUM_RO-1:0] reg_wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = AW - ADDR_LSB;
  localparam int NUM_RW   = C_NUM_REGS - C_NUM_RO;
  localparam int NUM_RO_W = (C_NUM_RO > 0) ? C_NUM_RO : 1;
  localparam int RW_SEL_W = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int RO_SEL_W = (NUM_RO_W > 1) ? $clog2(NUM_RO_W) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-path holding registers
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DW-1:0]     w_data;
  logic [STRB_W-1:0] w_strb;

  // Register file and status words
  logic [DW-1:0] regs        [NUM_RW];
  logic [DW-1:0] status_words[NUM_RO_W];

  // Handshakes and decode
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [31:0]         aw_idx_ext, ar_idx_ext;
  logic                aw_is_rw;
  logic [RW_SEL_W-1:0] aw_sel;
  logic [IDX_W-1:0]    ar_idx;
  logic [RO_SEL_W-1:0] ro_sel;
  logic [DW-1:0]       rd_data;
  logic [1:0]          rd_resp;
  logic                unused_bits;

  // The ready signals depend only on local state, so no AXI input reaches an AXI output combinationally.
  assign s_axi.awready = !aw_held && !s_axi.bvalid;
  assign s_axi.wready  = !w_held  && !s_axi.bvalid;
  assign s_axi.arready = !s_axi.rvalid;

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid  && s_axi.wready;
  assign b_hs   = s_axi.bvalid  && s_axi.bready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign r_hs   = s_axi.rvalid  && s_axi.rready;
  assign commit = aw_held && w_held;

  assign aw_idx_ext = 32'(aw_idx);
  assign aw_is_rw   = aw_idx_ext < 32'(NUM_RW);
  assign aw_sel     = aw_idx[RW_SEL_W-1:0];
  assign ar_idx     = s_axi.araddr[AW-1:ADDR_LSB];
  assign ar_idx_ext = 32'(ar_idx);
  assign ro_sel     = RO_SEL_W'(ar_idx_ext - 32'(NUM_RW));

  // The protection bits and the sub-word address bits have no meaning for this bank.
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  // Flatten the RW registers onto ctrl_regs, and split status_in into words.
  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_regs[g*DW +: DW] = regs[g];
  end
  for (genvar g = 0; g < NUM_RO_W; g++) begin : g_status
    assign status_words[g] = status_in[g*DW +: DW];
  end

  // Capture the write address. The holding register is released by the commit.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge inputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
    end else if (aw_hs) begin
      aw_held <= 1'b1;
      aw_idx  <= s_axi.awaddr[AW-1:ADDR_LSB];
    end else if (commit) begin
      aw_held <= 1'b0;
    end
  end

  // Capture write data and strobes. These are released by the commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_held <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (w_hs) begin
      w_held <= 1'b1;
      w_data <= s_axi.wdata;
      w_strb <= s_axi.wstrb;
    end else if (commit) begin
      w_held <= 1'b0;
    end
  end

  // Raise the write response on commit, and hold it until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_axi.bvalid <= 1'b1;
      s_axi.bresp  <= aw_is_rw ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      s_axi.bvalid <= 1'b0;
    end
  end

  // Apply committed writes to the RW registers byte by byte, and pulse the written index.
  // NOTE: the register array is reset explicitly, because software relies on C_RST_VAL after every reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_RW; i++) regs[i] <= C_RST_VAL;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && aw_is_rw) begin
        reg_wr_pulse[aw_sel] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) regs[aw_sel][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Decode the read address into data and a response.
  // Same-edge writes are not yet visible here, so a colliding read returns the old value.
  // NOTE: defaults come first, so no path through this block leaves an output unassigned (no latch).
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (ar_idx_ext < 32'(NUM_RW)) begin
      rd_data = regs[ar_idx[RW_SEL_W-1:0]];
      rd_resp = RESP_OKAY;
    end else if (ar_idx_ext < 32'(C_NUM_REGS)) begin
      rd_data = status_words[ro_sel];
      rd_resp = RESP_OKAY;
    end
  end

  // Load the read data channel on the AR handshake, and hold it until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
      s_axi.rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi.rvalid <= 1'b1;
      s_axi.rdata  <= rd_data;
      s_axi.rresp  <= rd_resp;
    end else if (r_hs) begin
      s_axi.rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_intellight_axil_regbank.sv
// Self-checking bench for intellight_axil_regbank, using the default configuration:
// 32-bit data, 8 registers, of which 2 are status registers.
// Expected values come from a word-array model of the register map.
module tb_intellight_axil_regbank;

  localparam int NUM_RW = 6;
  localparam int NUM_REGS = 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         aclk;
  logic         aresetn;
  logic [191:0] ctrl_regs;
  logic [63:0]  status_in;
  logic [5:0]   reg_wr_pulse;

  intellight_axil_regbank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  intellight_axil_regbank dut (
    .ACLK        (aclk),
    .ARESETN     (aresetn),
    .s_axi       (bus),
    .ctrl_regs   (ctrl_regs),
    .status_in   (status_in),
    .reg_wr_pulse(reg_wr_pulse)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain word arrays for the RW map and the status words.
  logic [31:0] m_rw     [NUM_RW];
  logic [31:0] m_status [2];
  int          pulse_cnt[NUM_RW];

  assign status_in = {m_status[1], m_status[0]};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count write pulses per register bit.
  always @(negedge aclk) begin
    for (int i = 0; i < NUM_RW; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
  end

  function automatic int idx_of(input logic [7:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [191:0] model_flat();
    logic [191:0] f;
    for (int i = 0; i < NUM_RW; i++) f[32*i +: 32] = m_rw[i];
    return f;
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int i;
    i = idx_of(addr);
    if (i < NUM_RW) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m_rw[i][8*b +: 8] = data[8*b +: 8];
      resp = OKAY;
    end else begin
      resp = SLVERR;
    end
  endtask

  task automatic model_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int i;
    i = idx_of(addr);
    if (i < NUM_RW) begin
      data = m_rw[i]; resp = OKAY;
    end else if (i < NUM_REGS) begin
      data = m_status[i-NUM_RW]; resp = OKAY;
    end else begin
      data = '0; resp = SLVERR;
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (bus.bvalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid=%b required 1 within 50 cycles", bus.bvalid);
      resp = 2'bxx;
    end else begin
      resp = bus.bresp;
    end
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (bus.rvalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL r_timeout: rvalid=%b required 1 within 50 cycles", bus.rvalid);
      data = 'x; resp = 2'bxx;
    end else begin
      data = bus.rdata; resp = bus.rresp;
    end
    @(negedge aclk);
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bit a_hs, w_hs;
    @(negedge aclk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      a_hs = bus.awvalid && (bus.awready === 1'b1);
      w_hs = bus.wvalid && (bus.wready === 1'b1);
      @(negedge aclk);
      n++;
      if (a_hs) bus.awvalid = 1'b0;
      if (w_hs) bus.wvalid = 1'b0;
    end
    if (bus.awvalid || bus.wvalid) begin
      checks++; errors++;
      $display("FAIL aw_w_timeout: awvalid=%b wvalid=%b still pending after 50 cycles",
               bus.awvalid, bus.wvalid);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    bit hs;
    @(negedge aclk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 50) begin
      hs = (bus.arready === 1'b1);
      @(negedge aclk);
      n++;
      if (hs) bus.arvalid = 1'b0;
    end
    if (bus.arvalid) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arvalid still pending after 50 cycles");
    end
    bus.arvalid = 1'b0;
    wait_r(data, resp);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: aw/w/ar ready=%b required 111", {bus.awready, bus.wready, bus.arready});
    end
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin
      errors++;
      $display("FAIL reset_resp: bvalid,rvalid,bresp,rresp=%b required 000000",
               {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
    end
    checks++;
    if (bus.rdata !== 32'h0 || reg_wr_pulse !== 6'b0) begin
      errors++;
      $display("FAIL reset_rdata_pulse: rdata=%h pulse=%b required 0", bus.rdata, reg_wr_pulse);
    end
    checks++;
    if (ctrl_regs !== model_flat()) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required %h", ctrl_regs, model_flat());
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_ready: got %b required 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_defaults();
    logic [1:0]  resp, exp_resp;
    logic [31:0] data, exp_data;
    int          pre[NUM_RW];
    for (int i = 0; i < NUM_RW; i++) begin
      for (int j = 0; j < NUM_RW; j++) pre[j] = pulse_cnt[j];
      model_write(8'(i*4), 32'(i+1), 4'hF, exp_resp);
      axi_write(8'(i*4), 32'(i+1), 4'hF, resp);
      checks++;
      if (resp !== exp_resp) begin
        errors++; $display("FAIL defaults_bresp[%0d]: got %b required %b", i, resp, exp_resp);
      end
      for (int j = 0; j < NUM_RW; j++) begin
        checks++;
        if (pulse_cnt[j] - pre[j] != ((j == i) ? 1 : 0)) begin
          errors++;
          $display("FAIL defaults_pulse[%0d] bit %0d: got %0d pulses required %0d",
                   i, j, pulse_cnt[j] - pre[j], (j == i) ? 1 : 0);
        end
      end
      checks++;
      if (ctrl_regs !== model_flat()) begin
        errors++; $display("FAIL defaults_ctrl[%0d]: got %h required %h", i, ctrl_regs, model_flat());
      end
    end
    for (int i = 0; i < NUM_RW; i++) begin
      model_read(8'(i*4), exp_data, exp_resp);
      axi_read(8'(i*4), data, resp);
      checks++;
      if (data !== 32'(i+1) || data !== exp_data || resp !== OKAY) begin
        errors++;
        $display("FAIL defaults_read[%0d]: got %h/%b required %h/%b", i, data, resp, exp_data, OKAY);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  resp, exp_resp;
    logic [31:0] data, exp_data;
    model_write(8'h04, 32'hAABBCCDD, 4'hF, exp_resp);
    axi_write(8'h04, 32'hAABBCCDD, 4'hF, resp);
    model_write(8'h04, 32'h11223344, 4'b0101, exp_resp);
    axi_write(8'h04, 32'h11223344, 4'b0101, resp);
    checks++;
    if (resp !== OKAY) begin
      errors++; $display("FAIL strobe_bresp: got %b required %b", resp, OKAY);
    end
    model_read(8'h04, exp_data, exp_resp);
    axi_read(8'h04, data, resp);
    checks++;
    if (data !== 32'hAA22CC44 || data !== exp_data || resp !== OKAY) begin
      errors++; $display("FAIL strobe_read: got %h/%b required %h/%b", data, resp, 32'hAA22CC44, OKAY);
    end
  endtask

  task automatic test_w_first();
    logic [1:0]  exp_resp;
    logic [31:0] wd;
    wd = $urandom;
    @(negedge aclk);
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    checks++;
    if (bus.wready !== 1'b0) begin
      errors++; $display("FAIL wfirst_wready_drop: got %b required 0", bus.wready);
    end
    repeat (2) @(negedge aclk);
    checks++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
      errors++; $display("FAIL wfirst_hold: wready=%b bvalid=%b required 0/0", bus.wready, bus.bvalid);
    end
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0) begin
      errors++; $display("FAIL wfirst_no_early_commit: bvalid=%b awready=%b required 0/0", bus.bvalid, bus.awready);
    end
    model_write(8'h08, wd, 4'hF, exp_resp);
    @(negedge aclk);
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
      errors++; $display("FAIL wfirst_commit: bvalid=%b bresp=%b required 1/%b", bus.bvalid, bus.bresp, exp_resp);
    end
    checks++;
    if (reg_wr_pulse !== 6'b000100 || ctrl_regs !== model_flat()) begin
      errors++; $display("FAIL wfirst_pulse_ctrl: pulse=%b ctrl=%h required 000100/%h", reg_wr_pulse, ctrl_regs, model_flat());
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      errors++; $display("FAIL wfirst_release: bvalid,awready,wready=%b required 011", {bus.bvalid, bus.awready, bus.wready});
    end
  endtask

  task automatic test_ro_oob();
    logic [1:0]  resp, exp_resp;
    logic [31:0] data, exp_data;
    int          pre_total, post_total;
    m_status[0] = 32'hCAFEF00D;
    m_status[1] = $urandom;
    axi_read(8'h18, data, resp);
    checks++;
    if (data !== 32'hCAFEF00D || resp !== OKAY) begin
      errors++; $display("FAIL ro_read0: got %h/%b required cafef00d/%b", data, resp, OKAY);
    end
    model_read(8'h1C, exp_data, exp_resp);
    axi_read(8'h1C, data, resp);
    checks++;
    if (data !== exp_data || resp !== exp_resp) begin
      errors++; $display("FAIL ro_read1: got %h/%b required %h/%b", data, resp, exp_data, exp_resp);
    end
    pre_total = 0;
    for (int j = 0; j < NUM_RW; j++) pre_total += pulse_cnt[j];
    model_write(8'h18, 32'h12345678, 4'hF, exp_resp);
    axi_write(8'h18, 32'h12345678, 4'hF, resp);
    post_total = 0;
    for (int j = 0; j < NUM_RW; j++) post_total += pulse_cnt[j];
    checks++;
    if (resp !== SLVERR || resp !== exp_resp) begin
      errors++; $display("FAIL ro_write_resp: got %b required %b", resp, SLVERR);
    end
    checks++;
    if (post_total != pre_total || ctrl_regs !== model_flat()) begin
      errors++; $display("FAIL ro_write_side_effect: pulses=%0d ctrl=%h required 0/%h", post_total - pre_total, ctrl_regs, model_flat());
    end
    axi_read(8'h18, data, resp);
    checks++;
    if (data !== 32'hCAFEF00D || resp !== OKAY) begin
      errors++; $display("FAIL ro_after_write: got %h/%b required cafef00d/%b", data, resp, OKAY);
    end
    axi_write(8'h40, 32'hDEADBEEF, 4'hF, resp);
    checks++;
    if (resp !== SLVERR || ctrl_regs !== model_flat()) begin
      errors++; $display("FAIL oob_write: resp=%b ctrl=%h required %b/%h", resp, ctrl_regs, SLVERR, model_flat());
    end
    axi_read(8'h40, data, resp);
    checks++;
    if (data !== 32'h0 || resp !== SLVERR) begin
      errors++; $display("FAIL oob_read: got %h/%b required 00000000/%b", data, resp, SLVERR);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  exp_resp;
    logic [31:0] wd, exp_data;
    int          n;
    wd = $urandom;
    model_write(8'h0C, wd, 4'hF, exp_resp);
    @(negedge aclk);
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100 || bus.bresp !== exp_resp) begin
        errors++;
        $display("FAIL bp_write[%0d]: bvalid,awready,wready=%b bresp=%b required 100/%b",
                 c, {bus.bvalid, bus.awready, bus.wready}, bus.bresp, exp_resp);
      end
      @(negedge aclk);
    end
    model_read(8'h0C, exp_data, exp_resp);
    bus.araddr = 8'h0C; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== exp_data || bus.rresp !== exp_resp) begin
        errors++;
        $display("FAIL bp_read[%0d]: rvalid,arready=%b rdata=%h rresp=%b required 10/%h/%b",
                 c, {bus.rvalid, bus.arready}, bus.rdata, bus.rresp, exp_data, exp_resp);
      end
      @(negedge aclk);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111) begin
      errors++;
      $display("FAIL bp_release: bvalid,rvalid,awready,wready,arready=%b required 00111",
               {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_same_edge();
    logic [1:0]  resp, exp_resp;
    logic [31:0] old_val, wd, data, exp_data;
    old_val = m_rw[1];
    wd = ~old_val ^ $urandom;
    @(negedge aclk);
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old_val || bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_read: rvalid=%b rdata=%h bvalid=%b required 1/%h/1",
               bus.rvalid, bus.rdata, bus.bvalid, old_val);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    model_write(8'h04, wd, 4'hF, exp_resp);
    model_read(8'h04, exp_data, exp_resp);
    axi_read(8'h04, data, resp);
    checks++;
    if (data !== exp_data || resp !== exp_resp) begin
      errors++; $display("FAIL same_edge_after: got %h/%b required %h/%b", data, resp, exp_data, exp_resp);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0]  resp, exp_resp;
    logic [31:0] wd, data, exp_data;
    @(negedge aclk);
    bus.awaddr = 8'h10; bus.awvalid = 1'b1;
    @(negedge aclk);
    checks++;
    if (bus.awready !== 1'b0) begin
      errors++; $display("FAIL midrst_aw_held: awready=%b required 0", bus.awready);
    end
    #2;
    aresetn = 1'b0;
    for (int i = 0; i < NUM_RW; i++) m_rw[i] = '0;
    #1;
    checks++;
    if ({bus.bvalid, bus.awready, bus.wready, bus.arready} !== 4'b0111 || reg_wr_pulse !== 6'b0) begin
      errors++;
      $display("FAIL midrst_state: bvalid,awready,wready,arready=%b pulse=%b required 0111/000000",
               {bus.bvalid, bus.awready, bus.wready, bus.arready}, reg_wr_pulse);
    end
    checks++;
    if (ctrl_regs !== model_flat()) begin
      errors++; $display("FAIL midrst_ctrl: got %h required %h", ctrl_regs, model_flat());
    end
    bus.awvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    wd = $urandom;
    model_write(8'h10, wd, 4'hF, exp_resp);
    axi_write(8'h10, wd, 4'hF, resp);
    model_read(8'h10, exp_data, exp_resp);
    axi_read(8'h10, data, resp);
    checks++;
    if (data !== exp_data || resp !== OKAY || ctrl_regs !== model_flat()) begin
      errors++; $display("FAIL midrst_recover: got %h/%b required %h/%b", data, resp, exp_data, OKAY);
    end
  endtask

  task automatic test_random();
    logic [1:0]  resp, exp_resp;
    logic [31:0] wd, data, exp_data;
    logic [3:0]  strb;
    logic [7:0]  addr;
    for (int it = 0; it < 60; it++) begin
      addr = 8'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = 8'hFC;
      if ($urandom_range(0, 3) == 0) m_status[$urandom_range(0, 1)] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        strb = 4'($urandom_range(0, 15));
        model_write(addr, wd, strb, exp_resp);
        axi_write(addr, wd, strb, resp);
        checks++;
        if (resp !== exp_resp || ctrl_regs !== model_flat()) begin
          errors++;
          $display("FAIL rand_write[%0d] addr=%h: resp=%b ctrl=%h required %b/%h",
                   it, addr, resp, ctrl_regs, exp_resp, model_flat());
        end
      end else begin
        model_read(addr, exp_data, exp_resp);
        axi_read(addr, data, resp);
        checks++;
        if (data !== exp_data || resp !== exp_resp) begin
          errors++;
          $display("FAIL rand_read[%0d] addr=%h: got %h/%b required %h/%b",
                   it, addr, data, resp, exp_data, exp_resp);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_RW; i++) begin
      m_rw[i] = '0;
      pulse_cnt[i] = 0;
    end
    m_status[0] = '0; m_status[1] = '0;
    aresetn = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    test_reset();
    test_defaults();
    test_strobe();
    test_w_first();
    test_ro_oob();
    test_backpressure();
    test_same_edge();
    test_reset_mid_write();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
